// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width, idle line level
// and the parity helper used by the TX and RX controllers.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam logic UART_LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        UART_ST_IDLE   = 3'd0,
        UART_ST_START  = 3'd1,
        UART_ST_DATA   = 3'd2,
        UART_ST_PARITY = 3'd3,
        UART_ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity is the XOR of all data bits; odd parity is its complement.
    function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter: counts oversample ticks and
// strobes bit_end on the last tick of every bit period.
module uart_tx_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign bit_end = tick && !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmitter: one-entry holding register behind a valid/ready handshake,
// 8N1 serialiser; optional parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int TX_OVERSAMPLE = 16,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_Tick,
    input  logic                   i_Tx_Valid,
    input  logic [UART_DATA_W-1:0] i_Tx_Byte,
    output logic                   o_Tx_Ready,
    output logic                   o_Tx_Serial,
    output logic                   o_Tx_Active,
    output logic                   o_Tx_Done
);

    generate
        if (TX_OVERSAMPLE < 2) begin : g_bad_oversample
            $error("uart_tx_controller: TX_OVERSAMPLE must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_controller: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
            $error("uart_tx_controller: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t            state, state_next;
    logic [UART_DATA_W-1:0] shift, shift_next;
    logic [2:0]             bit_idx, bit_idx_next;
    logic                   stop_idx, stop_idx_next;
    logic                   line, line_next;
    logic                   active, active_next;
    logic                   done, done_next;
    logic [UART_DATA_W-1:0] hold_data, hold_data_next;
    logic                   hold_full, hold_full_next;
    logic                   load;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit, parity_bit_next;
`endif

    uart_tx_bit_timer #(
        .OVERSAMPLE(TX_OVERSAMPLE)
    ) u_bit_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (i_Tick),
        .clear  (state == UART_ST_IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= UART_ST_IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            line       <= UART_LINE_IDLE;
            active     <= 1'b0;
            done       <= 1'b0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_idx    <= bit_idx_next;
            stop_idx   <= stop_idx_next;
            line       <= line_next;
            active     <= active_next;
            done       <= done_next;
            hold_data  <= hold_data_next;
            hold_full  <= hold_full_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_bit_next;
`endif
        end
    end

    always_comb begin
        state_next      = state;
        shift_next      = shift;
        bit_idx_next    = bit_idx;
        stop_idx_next   = stop_idx;
        line_next       = line;
        active_next     = active;
        done_next       = 1'b0;
        hold_data_next  = hold_data;
        hold_full_next  = hold_full;
        load            = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_bit_next = parity_bit;
`endif

        case (state)
            UART_ST_IDLE: begin
                if (i_Tick && hold_full) begin
                    load = 1'b1;
                end
            end
            UART_ST_START: begin
                if (bit_end) begin
                    state_next   = UART_ST_DATA;
                    line_next    = shift[0];
                    shift_next   = shift >> 1;
                    bit_idx_next = '0;
                end
            end
            UART_ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next    = UART_ST_PARITY;
                        line_next     = parity_bit;
`else
                        state_next    = UART_ST_STOP;
                        line_next     = UART_LINE_IDLE;
                        stop_idx_next = 1'b0;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        line_next    = shift[0];
                        shift_next   = shift >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_ST_PARITY: begin
                if (bit_end) begin
                    state_next    = UART_ST_STOP;
                    line_next     = UART_LINE_IDLE;
                    stop_idx_next = 1'b0;
                end
            end
`endif
            UART_ST_STOP: begin
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        done_next = 1'b1;
                        // A waiting byte starts its frame on this same tick, with no idle gap.
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_next  = UART_ST_IDLE;
                            active_next = 1'b0;
                        end
                    end else begin
                        stop_idx_next = stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next  = UART_ST_IDLE;
                line_next   = UART_LINE_IDLE;
                active_next = 1'b0;
            end
        endcase

        if (load) begin
            state_next      = UART_ST_START;
            shift_next      = hold_data;
            line_next       = 1'b0;
            active_next     = 1'b1;
            hold_full_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit_next = uart_parity(hold_data, PARITY_ODD != 0);
`endif
        end

        // Accept and drain are mutually exclusive: accept needs the register empty.
        if (i_Tx_Valid && !hold_full) begin
            hold_full_next = 1'b1;
            hold_data_next = i_Tx_Byte;
        end
    end

    assign o_Tx_Ready  = !hold_full;
    assign o_Tx_Serial = line;
    assign o_Tx_Active = active;
    assign o_Tx_Done   = done;

endmodule
